// File: rtl/uart_tx_serializer_if.sv
// Byte-in / serial-out handshake bundle for the UART transmit stage.
interface uart_tx_serializer_if;
  logic [7:0] data_parallel;
  logic       send;
  logic       tx;
  logic       busy;
  logic       done;

  // Controlling logic drives the byte and request, observes line and status.
  modport master (output data_parallel, output send, input tx, input busy, input done);
  // Serializer consumes the byte and request, drives line and status.
  modport slave  (input data_parallel, input send, output tx, output busy, output done);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 8 data bits LSB-first, optional parity, stop.
// Bit timing comes from a per-bit baud counter; all outputs are registered.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  uart_tx_serializer_if.slave  bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  // Last cycle of the current bit period.
  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // State, datapath and registered outputs; reset parks the line high.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state plus counter/shift updates; the byte and parity latch only on accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (bus.send) begin
          state_d = START;
          shift_d = bus.data_parallel;
          par_d   = (^bus.data_parallel) ^ PARITY_ODD;
        end
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is heading.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench: three serializers (8N1, 8E1, 8O1) share one stimulus and are checked
// every cycle against a frame-level model built from the bit list of each byte.
module tb_uart_tx_serializer;
  localparam int C = 4;
  localparam logic [2:0] PEN  = 3'b110;
  localparam logic [2:0] PODD = 3'b100;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;
  int         bcnt[3];
  int         dcnt[3];

  always #5 Clk = ~Clk;

  uart_tx_serializer_if bus0 ();
  uart_tx_serializer_if bus1 ();
  uart_tx_serializer_if bus2 ();
  assign bus0.send = send;  assign bus0.data_parallel = data;
  assign bus1.send = send;  assign bus1.data_parallel = data;
  assign bus2.send = send;  assign bus2.data_parallel = data;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus0));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
    dut2 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus2));

  logic [2:0] tx_o, busy_o, done_o;
  assign tx_o   = {bus2.tx,   bus1.tx,   bus0.tx};
  assign busy_o = {bus2.busy, bus1.busy, bus0.busy};
  assign done_o = {bus2.done, bus1.done, bus0.done};

  // Frame as a list of line levels, index 0 sent first.
  function automatic logic [10:0] frame(input logic [7:0] b, input bit pen, input bit podd);
    logic p;
    p = (^b) ^ podd;
    if (pen) return {1'b1, p, b, 1'b0};
    return {2'b11, b, 1'b0};
  endfunction

  // Reference: a frame occupies (10+PEN)*C cycles from acceptance; done follows it.
  logic       m_act[3];
  int         m_t[3];
  logic [10:0] m_bits[3];
  logic       m_done[3];
  always @(posedge Clk or negedge Rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!Rst_n) begin
        m_act[k]  <= 1'b0;
        m_t[k]    <= 0;
        m_bits[k] <= '1;
        m_done[k] <= 1'b0;
      end else begin
        m_done[k] <= 1'b0;
        if (!m_act[k]) begin
          if (send) begin
            m_act[k]  <= 1'b1;
            m_t[k]    <= 0;
            m_bits[k] <= frame(data, PEN[k], PODD[k]);
          end
        end else if (m_t[k] == (10 + int'(PEN[k])) * C - 1) begin
          m_act[k]  <= 1'b0;
          m_done[k] <= 1'b1;
        end else begin
          m_t[k] <= m_t[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx(input int k);
    return m_act[k] ? m_bits[k][m_t[k] / C] : 1'b1;
  endfunction

  // One clock: sample just after the edge, compare all DUTs with the model.
  task automatic tick();
    @(posedge Clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx%0d", k),   32'(tx_o[k]),   32'(exp_tx(k)));
      chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_act[k]));
      chk($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_done[k]));
      bcnt[k] += int'(busy_o[k]);
      dcnt[k] += int'(done_o[k]);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_byte(input logic [7:0] b);
    data = b;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  int b0[3];
  int d0[3];
  task automatic snap();
    for (int k = 0; k < 3; k++) begin b0[k] = bcnt[k]; d0[k] = dcnt[k]; end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin bcnt[k] = 0; dcnt[k] = 0; end

    // Reset held with random inputs
    send = 1'b1;
    data = 8'($urandom);
    ticks(3);
    Rst_n = 1'b1;
    send = 1'b0;
    ticks(2);

    // 8N1 byte 0x05, single-cycle request
    snap();
    start_byte(8'h05);
    ticks(50);
    chk("busy_len_8n1", 32'(bcnt[0] - b0[0]), 32'd40);
    chk("busy_len_8e1", 32'(bcnt[1] - b0[1]), 32'd44);
    chk("done_cnt_8n1", 32'(dcnt[0] - d0[0]), 32'd1);

    // Parity of 0x07: even -> 1, odd -> 0, sampled inside the parity bit
    start_byte(8'h07);
    ticks(37);
    chk("par_even", 32'(bus1.tx), 32'd1);
    chk("par_odd",  32'(bus2.tx), 32'd0);
    ticks(12);

    // Re-request and data change mid-frame are ignored
    snap();
    start_byte(8'h05);
    ticks(10);
    data = 8'h03;
    send = 1'b1;
    tick();
    send = 1'b0;
    ticks(45);
    for (int k = 0; k < 3; k++) chk($sformatf("one_frame%0d", k), 32'(dcnt[k] - d0[k]), 32'd1);

    // Request held high: back-to-back frames with a single idle cycle
    snap();
    data = 8'h02;
    send = 1'b1;
    ticks(3 * 41);
    send = 1'b0;
    ticks(50);
    chk("b2b_frames8n1", 32'(dcnt[0] - d0[0]), 32'd3);
    chk("b2b_busy8n1",   32'(bcnt[0] - b0[0]), 32'd120);

    // Reset during DATA bit 3, then a clean frame
    start_byte(8'h06);
    ticks(16);
    #2 Rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_tx%0d", k),   32'(tx_o[k]),   32'd1);
      chk($sformatf("arst_busy%0d", k), 32'(busy_o[k]), 32'd0);
      chk($sformatf("arst_done%0d", k), 32'(done_o[k]), 32'd0);
    end
    snap();
    ticks(2);
    Rst_n = 1'b1;
    ticks(1);
    start_byte(8'h01);
    ticks(50);
    chk("post_rst_done", 32'(dcnt[0] - d0[0]), 32'd1);
    chk("post_rst_busy", 32'(bcnt[1] - b0[1]), 32'd44);

    // Random traffic, occasional resets
    for (int i = 0; i < 1500; i++) begin
      data = 8'($urandom);
      send = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
